alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one instance of the team's `ALU` between two requesters, such as the execute stage and an address-generation unit. It accepts one operation at a time through a valid/ready handshake and registers the operands. It runs them through `ALU` and returns the registered result and NZCV flags to the requester that issued the operation.

## Interface
- `N`, default 32: operand/result width, passed to `ALU #(N)`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `valid0`, `valid1` input 1 each: requester has an operation pending.
- `ready0`, `ready1` output 1 each: operation accepted this cycle (transfer when `validX && readyX`).
- `a0`, `b0`, `a1`, `b1` input N each: operands.
- `op0`, `op1` input 4 each: ALU select code, forwarded unmodified to `ALU.s`.
- `rsp_valid0`, `rsp_valid1` output 1 each: one-cycle response strobe.
- `rsp_z` output N: registered result, shared by both requesters.
- `rsp_flags` output 4: registered flags {N,Z,C,V}, shared.
- `busy` output 1: high in any state other than IDLE.
- `lock0`, `lock1` input 1 each: present only with `ALU_ARB_LOCK_EN`.

## Operation
- FSM states:
  - IDLE: a grant is possible.
  - EXEC: the ALU evaluates the captured operands.
  - RESP: the response is presented.
- IDLE:
  - If any `validX` is high, the winner's `readyX` is asserted combinationally.
  - On that edge, `a`, `b`, `op` and the winner ID are captured; next state is EXEC.
  - If no valid is high, the FSM stays in IDLE.
- EXEC: ALU inputs come only from the captured registers. `z`/`flags` are latched into `rsp_z`/`rsp_flags`; next state is RESP.
- RESP:
  - `rsp_validX` is high for the captured ID only, then the FSM returns to IDLE.
  - No backpressure: the requester must sample in this cycle.
- Arbitration:
  - The `last` pointer records the most recent grant.
  - When both requesters are valid, the one not equal to `last` wins.
  - When only one is valid, it wins regardless of `last`.
- `ready0 && ready1` is never high in the same cycle. `readyX` is never high outside IDLE.
- Requester obligations:
  - Hold `validX` and the operands stable until `readyX`.
  - Dropping `validX` before the grant is allowed; no operation occurs.
- Op codes are not checked. Undefined codes produce whatever `ALU` outputs, and a response is still issued.
- `rsp_z`/`rsp_flags` hold their value until the next EXEC.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so requester 0 wins the first contention.
  - All `readyX`, `rsp_validX` and `busy` = 0.
  - `rsp_z` = 0, `rsp_flags` = 0.
- Latency:
  - The accept edge is E0. `rsp_validX` is high in the cycle between E1 and E2, i.e. 2 cycles after the accept cycle.
  - Throughput is one operation per 3 cycles.
- The earliest next grant is in the IDLE cycle following RESP. New `validX` seen during EXEC/RESP waits.
- Simultaneous valids in IDLE: the grant follows the round-robin rule and the loser's `ready` stays 0.
- The same requester re-asserting valid immediately after its response is granted if the other is idle.
- Reset mid-operation:
  - `rst` low in EXEC or RESP forces IDLE asynchronously.
  - The pending operation is discarded; no `rsp_valid` is issued, even if reset falls during RESP.
  - `last` returns to 1.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - `lock0`/`lock1` ports exist.
  - A grant made while the winner's `lockX` is high sets a lock owner.
  - While a lock owner exists, only the owner can be granted in IDLE; the other requester's valid is ignored.
  - The lock clears on the first grant to the owner with `lockX` low, or on reset.
  - `last` is not updated while locked.
- Not defined: no lock ports, no lock state; pure round-robin.

## Test plan
- Reset, then req0 only: `a0`=1, `b0`=1, `op0`=0000 (N=3).
  - Required: `ready0` high in the first cycle; `rsp_valid0` high 2 cycles later with `rsp_z`=010, `rsp_flags`=0000; `rsp_valid1` stays 0.
- req1 only: `a1`=1, `b1`=1, `op1`=0001.
  - Required: `rsp_valid1` with `rsp_z`=000, `rsp_flags`=0110; `busy` high for exactly 2 cycles.
- Both valid continuously after reset, with distinct operands.
  - Required: grants alternate 0,1,0,1; each response carries the matching requester's result; `ready0 && ready1` is never observed.
- Assert `rst` low during EXEC.
  - Required: immediate IDLE; no `rsp_valid`; all outputs at reset values; the next grant follows normal timing.
- `valid0` pulses for one cycle while the FSM is busy with req1, then drops.
  - Required: no grant to req0 and no `rsp_valid0`.
- With `ALU_ARB_LOCK_EN`: req0 granted with `lock0`=1 while both valid.
  - Required: the next two grants go to req0.
  - Then req0 is granted with `lock0`=0; the following grant goes to req1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two valid/ready requesters.
// Optional ALU_ARB_LOCK_EN adds lock0/lock1 so one requester can hold the ALU across grants.

module ALU #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   s,
    output logic [N-1:0] z,
    output logic [3:0]   flags
);

    logic [N:0] sum;
    logic       carry;
    logic       ovf;

    // Subtraction yields C=1 when no borrow occurs; unknown select codes yield zero.
    always_comb begin
        sum   = '0;
        z     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (s)
            4'h0: begin
                sum   = {1'b0, a} + {1'b0, b};
                z     = sum[N-1:0];
                carry = sum[N];
                ovf   = (a[N-1] == b[N-1]) && (z[N-1] != a[N-1]);
            end
            4'h1: begin
                sum   = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                z     = sum[N-1:0];
                carry = sum[N];
                ovf   = (a[N-1] != b[N-1]) && (z[N-1] != a[N-1]);
            end
            4'h2: z = a & b;
            4'h3: z = a | b;
            4'h4: z = a ^ b;
            4'h5: z = ~a;
            4'h6: begin
                z     = {a[N-2:0], 1'b0};
                carry = a[N-1];
            end
            4'h7: begin
                z     = {1'b0, a[N-1:1]};
                carry = a[0];
            end
            4'h8: z = b;
            default: z = '0;
        endcase
        flags = {z[N-1], (z == '0), carry, ovf};
    end

endmodule

module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ALU_ARB_LOCK_EN
    input  logic         lock0,
    input  logic         lock1,
`endif
    input  logic         valid0,
    input  logic         valid1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [3:0]   op0,
    input  logic [3:0]   op1,
    output logic         ready0,
    output logic         ready1,
    output logic         rsp_valid0,
    output logic         rsp_valid1,
    output logic [N-1:0] rsp_z,
    output logic [3:0]   rsp_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    state_t       state_next;

    logic         last;
    logic         cap_id;
    logic [N-1:0] cap_a;
    logic [N-1:0] cap_b;
    logic [3:0]   cap_op;

    logic         elig0;
    logic         elig1;
    logic         winner;
    logic         grant;

    logic [N-1:0] alu_z;
    logic [3:0]   alu_flags;

`ifdef ALU_ARB_LOCK_EN
    logic         locked;
    logic         owner;
    logic         winner_lock;

    // A held lock masks the non-owner out of arbitration entirely.
    always_comb begin
        elig0       = valid0 && (!locked || !owner);
        elig1       = valid1 && (!locked || owner);
        winner_lock = winner ? lock1 : lock0;
    end
`else
    always_comb begin
        elig0 = valid0;
        elig1 = valid1;
    end
`endif

    // On contention the requester that did not win last time goes first.
    assign winner = (elig0 && elig1) ? ~last : elig1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                grant  = elig0 || elig1;
                ready0 = grant && !winner;
                ready1 = grant && winner;
                if (grant) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid0 = !cap_id;
                rsp_valid1 = cap_id;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands and requester ID are frozen at grant so the requester may move on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_a  <= '0;
            cap_b  <= '0;
            cap_op <= '0;
            cap_id <= 1'b0;
        end else if (grant) begin
            cap_a  <= winner ? a1 : a0;
            cap_b  <= winner ? b1 : b0;
            cap_op <= winner ? op1 : op0;
            cap_id <= winner;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // The round-robin pointer is frozen while an owner holds the lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last   <= 1'b1;
            locked <= 1'b0;
            owner  <= 1'b0;
        end else if (grant) begin
            if (!locked) begin
                last <= winner;
                if (winner_lock) begin
                    locked <= 1'b1;
                    owner  <= winner;
                end
            end else if (!winner_lock) begin
                locked <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (grant) begin
            last <= winner;
        end
    end
`endif

    ALU #(.N(N)) u_alu (
        .a     (cap_a),
        .b     (cap_b),
        .s     (cap_op),
        .z     (alu_z),
        .flags (alu_flags)
    );

    // Response registers keep their contents until the next operation executes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_z     <= '0;
            rsp_flags <= '0;
        end else if (state == EXEC) begin
            rsp_z     <= alu_z;
            rsp_flags <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter, checked against a cycle-level reference model.
// Lock scenarios are compiled in only when ALU_ARB_LOCK_EN is defined.

module tb_alu_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid0, valid1;
    logic [N-1:0] a0, b0, a1, b1;
    logic [3:0]   op0, op1;
    logic         ready0, ready1;
    logic         rsp_valid0, rsp_valid1;
    logic [N-1:0] rsp_z;
    logic [3:0]   rsp_flags;
    logic         busy;
`ifdef ALU_ARB_LOCK_EN
    logic         lock0, lock1;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ALU_ARB_LOCK_EN
        .lock0      (lock0),
        .lock1      (lock1),
`endif
        .valid0     (valid0),
        .valid1     (valid1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .op0        (op0),
        .op1        (op1),
        .ready0     (ready0),
        .ready1     (ready1),
        .rsp_valid0 (rsp_valid0),
        .rsp_valid1 (rsp_valid1),
        .rsp_z      (rsp_z),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: cycles left until the arbiter is free again, plus held response.
    int           m_left;
    int           m_id;
    int           m_last;
    bit           m_locked;
    int           m_owner;
    logic [N-1:0] m_res, m_z;
    logic [3:0]   m_resf, m_flags;
    int           granted;

    function automatic logic [N+3:0] refAlu(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int smax = 2 ** (N - 1) - 1;
        int smin = -(2 ** (N - 1));
        logic [N-1:0] z = '0;
        bit c = 0;
        bit v = 0;
        case (op)
            4'd0: begin z = N'(ua + ub); c = (ua + ub) >= 2 ** N; v = (sa + sb > smax) || (sa + sb < smin); end
            4'd1: begin z = N'(ua - ub); c = ua >= ub; v = (sa - sb > smax) || (sa - sb < smin); end
            4'd2: z = a & b;
            4'd3: z = a | b;
            4'd4: z = a ^ b;
            4'd5: z = ~a;
            4'd6: begin z = N'(ua * 2); c = ua >= 2 ** (N - 1); end
            4'd7: begin z = N'(ua / 2); c = (ua % 2) == 1; end
            4'd8: z = b;
            default: z = '0;
        endcase
        return {z[N-1], z == '0, c, v, z};
    endfunction

    function automatic int pickWinner(input bit v0, input bit v1);
        bit e0 = v0 && (!m_locked || m_owner == 0);
        bit e1 = v1 && (!m_locked || m_owner == 1);
        if (e0 && e1) return 1 - m_last;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        m_left   = 0;
        m_id     = 0;
        m_last   = 1;
        m_locked = 0;
        m_owner  = 0;
        m_z      = '0;
        m_flags  = '0;
        granted  = -1;
    endtask

    // Called just after a falling edge with inputs already driven; returns on the next falling edge.
    task automatic applyStimulus();
        int w;
        bit lk;
        #1;
        w = (m_left == 0) ? pickWinner(valid0, valid1) : -1;
        checkOutput("ready0", ready0, w == 0);
        checkOutput("ready1", ready1, w == 1);
        checkOutput("rsp_valid0", rsp_valid0, m_left == 1 && m_id == 0);
        checkOutput("rsp_valid1", rsp_valid1, m_left == 1 && m_id == 1);
        checkOutput("busy", busy, m_left != 0);
        checkOutput("rsp_z", rsp_z, m_z);
        checkOutput("rsp_flags", rsp_flags, m_flags);
        @(posedge clk);
        granted = -1;
        if (m_left == 0 && w >= 0) begin
            granted = w;
            m_id = w;
            {m_resf, m_res} = (w == 1) ? refAlu(op1, a1, b1) : refAlu(op0, a0, b0);
            m_left = 2;
`ifdef ALU_ARB_LOCK_EN
            lk = (w == 1) ? lock1 : lock0;
`else
            lk = 0;
`endif
            if (!m_locked) begin
                m_last = w;
                if (lk) begin
                    m_locked = 1;
                    m_owner = w;
                end
            end else if (!lk) begin
                m_locked = 0;
            end
        end else if (m_left == 2) begin
            m_z = m_res;
            m_flags = m_resf;
            m_left = 1;
        end else if (m_left == 1) begin
            m_left = 0;
        end
        @(negedge clk);
    endtask

    // Asserts reset part-way through a cycle and expects outputs to clear immediately.
    task automatic pulseReset();
        valid0 = 0;
        valid1 = 0;
        #2 rst = 0;
        #1;
        checkOutput("rst_ready0", ready0, 0);
        checkOutput("rst_ready1", ready1, 0);
        checkOutput("rst_rsp_valid0", rsp_valid0, 0);
        checkOutput("rst_rsp_valid1", rsp_valid1, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_z", rsp_z, 0);
        checkOutput("rst_rsp_flags", rsp_flags, 0);
        modelReset();
        @(negedge clk);
        rst = 1;
    endtask

    bit pend0, pend1;
    int grants[$];
    int busyCount;
    int seen0;

    initial begin
        rst = 0;
        {valid0, valid1} = '0;
        {a0, b0, a1, b1} = '0;
        {op0, op1} = '0;
`ifdef ALU_ARB_LOCK_EN
        {lock0, lock1} = '0;
`endif
        modelReset();
        @(negedge clk);
        applyStimulus();
        rst = 1;

        // Single request from requester 0: 1 + 1.
        a0 = 1; b0 = 1; op0 = 4'b0000; valid0 = 1;
        applyStimulus();
        checkOutput("t1_granted", granted, 0);
        valid0 = 0;
        applyStimulus();
        #1;
        checkOutput("t1_rsp_valid0", rsp_valid0, 1);
        checkOutput("t1_rsp_z", rsp_z, 2);
        checkOutput("t1_rsp_flags", rsp_flags, 4'b0000);
        applyStimulus();

        // Single request from requester 1: 1 - 1, busy for exactly two cycles.
        a1 = 1; b1 = 1; op1 = 4'b0001; valid1 = 1;
        applyStimulus();
        valid1 = 0;
        busyCount = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (busy) busyCount++;
            if (i == 1) begin
                checkOutput("t2_rsp_valid1", rsp_valid1, 1);
                checkOutput("t2_rsp_z", rsp_z, 0);
                checkOutput("t2_rsp_flags", rsp_flags, 4'b0110);
            end
            applyStimulus();
        end
        checkOutput("t2_busy_cycles", busyCount, 2);

        // Both requesters valid continuously from reset.
        pulseReset();
        valid0 = 1; valid1 = 1;
        a0 = 8'h10; b0 = 8'h03; op0 = 4'd0;
        a1 = 8'h22; b1 = 8'h05; op1 = 4'd1;
        grants.delete();
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (granted == 0) begin grants.push_back(0); a0 = N'($urandom); b0 = N'($urandom); op0 = 4'($urandom_range(0, 4)); end
            if (granted == 1) begin grants.push_back(1); a1 = N'($urandom); b1 = N'($urandom); op1 = 4'($urandom_range(0, 4)); end
        end
        checkOutput("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            checkOutput($sformatf("t3_grant%0d", i), grants[i], i % 2);
        valid0 = 0; valid1 = 0;
        repeat (3) applyStimulus();

        // Reset while executing: no response, then requester 0 wins the next contention.
        a0 = 8'h40; b0 = 8'h40; op0 = 4'd0; valid0 = 1;
        applyStimulus();
        pulseReset();
        a1 = 8'h07; b1 = 8'h01; op1 = 4'd2;
        valid0 = 1; valid1 = 1;
        applyStimulus();
        checkOutput("t4_grant_after_reset", granted, 0);
        valid0 = 0; valid1 = 0;
        repeat (3) applyStimulus();

        // A one-cycle valid0 while requester 1 is being served is never granted.
        valid1 = 1; a1 = 8'h33; b1 = 8'h11; op1 = 4'd4;
        applyStimulus();
        valid1 = 0; valid0 = 1; a0 = 8'h99;
        seen0 = 0;
        applyStimulus();
        valid0 = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid0) seen0++;
            applyStimulus();
        end
        checkOutput("t5_no_rsp0", seen0, 0);

`ifdef ALU_ARB_LOCK_EN
        // Locked requester 0 keeps the ALU until it is granted with lock0 low.
        pulseReset();
        valid0 = 1; valid1 = 1; lock0 = 1; lock1 = 0;
        grants.delete();
        for (int i = 0; i < 18; i++) begin
            applyStimulus();
            if (granted >= 0) grants.push_back(granted);
            if (granted == 0) lock0 = (grants.size() < 3);
        end
        checkOutput("lock_grant_count", grants.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            checkOutput($sformatf("lock_grant%0d", i), grants[i], (i == 4) ? 1 : 0);
        valid0 = 0; valid1 = 0; lock0 = 0;
        repeat (3) applyStimulus();
`endif

        // Randomized traffic with occasional withdrawn requests and mid-operation resets.
        pend0 = 0; pend1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 73 == 72) begin
                pulseReset();
                pend0 = 0; pend1 = 0;
            end
            if (!pend0 && $urandom_range(0, 99) < 45) begin
                pend0 = 1; a0 = N'($urandom); b0 = N'($urandom); op0 = 4'($urandom_range(0, 15));
`ifdef ALU_ARB_LOCK_EN
                lock0 = ($urandom_range(0, 3) == 0);
`endif
            end else if (pend0 && $urandom_range(0, 99) < 4) begin
                pend0 = 0;
            end
            if (!pend1 && $urandom_range(0, 99) < 45) begin
                pend1 = 1; a1 = N'($urandom); b1 = N'($urandom); op1 = 4'($urandom_range(0, 15));
`ifdef ALU_ARB_LOCK_EN
                lock1 = ($urandom_range(0, 3) == 0);
`endif
            end else if (pend1 && $urandom_range(0, 99) < 4) begin
                pend1 = 0;
            end
            valid0 = pend0;
            valid1 = pend1;
            applyStimulus();
            if (granted == 0) pend0 = 0;
            if (granted == 1) pend1 = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
